demux32_reg: RTL

Registered 1-to-2 demultiplexer for 32-bit words with valid/ready handshakes on all three sides. It routes each accepted input word to destination A or B according to a per-word select bit, and is the counterpart of the 32-bit 2:1 source mux in the MIPS datapath. It holds at most one word in flight, sustains one transfer per cycle when the addressed sink is ready, and keeps per-destination delivery counters for debug.

---
 rtl/demux32_reg.sv | 84 ++++++++
 1 files changed

// File: rtl/demux32_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes on all sides.
// Holds at most one word and steers it to destination A or B by its select bit.
module demux32_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             busy
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL_A = 2'd1,
        FULL_B = 2'd2
    } state_t;

    state_t state;
    logic   a_xfer;
    logic   b_xfer;
    logic   in_xfer;

    // Only the addressed sink's ready matters; the other one is ignored.
    always_comb begin
        a_xfer   = (state == FULL_A) && a_ready;
        b_xfer   = (state == FULL_B) && b_ready;
        in_ready = !reset && ((state == EMPTY) || a_xfer || b_xfer);
        in_xfer  = in_valid && in_ready;
    end

    // Data outputs are registered per destination, so the idle side reads zero
    // without a separate buffer-and-mux stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            a_data  <= '0;
            b_data  <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            busy    <= 1'b0;
            cnt_a   <= '0;
            cnt_b   <= '0;
        end else begin
            if (in_xfer) begin
                busy <= 1'b1;
                if (in_sel) begin
                    state   <= FULL_B;
                    a_data  <= '0;
                    b_data  <= in_data;
                    a_valid <= 1'b0;
                    b_valid <= 1'b1;
                end else begin
                    state   <= FULL_A;
                    a_data  <= in_data;
                    b_data  <= '0;
                    a_valid <= 1'b1;
                    b_valid <= 1'b0;
                end
            end else if (a_xfer || b_xfer) begin
                state   <= EMPTY;
                a_data  <= '0;
                b_data  <= '0;
                a_valid <= 1'b0;
                b_valid <= 1'b0;
                busy    <= 1'b0;
            end
            if (a_xfer) cnt_a <= cnt_a + 1'b1;
            if (b_xfer) cnt_b <= cnt_b + 1'b1;
        end
    end

endmodule
